thunder_cmd_sched: RTL and testbench
====================================

Name: thunder_cmd_sched

Overview:
Command scheduler for the Thunderbolt GPSDO serial link. It arbitrates two command requesters, for example a config FSM and a host-side poller, onto the single TSIP transmit UART. For each granted request it frames one TSIP packet (DLE, ID, optional parameter, DLE, ETX) with DLE stuffing. It then waits for the matching response ID from the thunderbolt packet receiver, or for a timeout, before serving the next request.

Parameters:
TIMEOUT_CYC, 10000000, response timeout in i_clk cycles (1 s at 10 MHz); counter width 24 bits.
DLE, 8'h10, TSIP framing/escape byte.
ETX, 8'h03, TSIP end-of-text byte.

Ports:
i_clk  in  1  system clock (10 MHz)
i_rst  in  1  synchronous active-high reset
i_req  in  2  request level per requester; held until o_ack bit
i_req_id  in  16  command ID; [7:0] req0, [15:8] req1
i_req_param  in  16  parameter byte per requester, same packing
i_req_has_param  in  2  1 = send parameter byte
i_req_rsp_id  in  16  expected response packet ID per requester
o_ack  out  2  1-cycle pulse; request fields sampled this cycle
o_done  out  2  1-cycle pulse; matching response received
o_timeout  out  2  1-cycle pulse; no matching response in time
o_busy  out  1  high from ack until done/timeout pulse inclusive
o_tx_byte  out  8  byte to UART transmitter
o_tx_dv  out  1  byte valid
i_tx_ready  in  1  UART can accept; transfer when o_tx_dv & i_tx_ready
i_rsp_dv  in  1  1-cycle pulse, decoded response packet available
i_rsp_id  in  8  ID of that response packet

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = 1 (req0 wins first), counters 0, latched fields 0.
- Reset mid-operation: abandon the partial frame and go to IDLE next edge. o_tx_dv is 0 from the first reset cycle. No done/timeout pulse.
- States: IDLE, DLE0, ID, ID_ESC, PARAM, PARAM_ESC, DLE1, ETX, WAIT_RSP, FIN.
- IDLE: if any i_req bit is set, grant round-robin (the requester after the last served wins; a single requester always wins).
  - Pulse o_ack[g], latch id/param/has_param/rsp_id, set o_busy, update rr pointer, go to DLE0.
  - Latency: req high in cycle N gives o_ack in cycle N+1 (registered). o_tx_dv rises in cycle N+2.
- Send states: drive o_tx_dv=1 with the state's byte; advance only on a cycle where i_tx_ready=1. Bytes per state:
  - DLE0: DLE.
  - ID: id; then ID_ESC if id==DLE, else next.
  - ID_ESC: DLE.
  - PARAM: skipped if !has_param; sends param; then PARAM_ESC if param==DLE.
  - PARAM_ESC: DLE.
  - DLE1: DLE.
  - ETX: ETX, then go to WAIT_RSP.
  - o_tx_dv may stay high across back-to-back bytes; o_tx_byte is stable while o_tx_dv=1 and !i_tx_ready.
- WAIT_RSP: o_tx_dv=0. Counter clears on entry and increments each cycle.
  - i_rsp_dv with i_rsp_id == latched rsp_id: go to FIN with done.
  - Non-matching responses are ignored and do not reset the counter.
  - Counter reaching TIMEOUT_CYC-1 without a match: go to FIN with timeout.
  - Match and expiry in the same cycle: done wins.
- Response pulses outside WAIT_RSP are ignored, including ones arriving during frame send.
- FIN (1 cycle): pulse o_done[g] or o_timeout[g], then go to IDLE. o_busy drops the cycle after FIN.
  - Minimum gap FIN to the next o_ack is 1 cycle.
- Requests are never queued internally; a requester deasserting before o_ack is simply not served.

Optional Feature:
THUNDER_SCHED_RETRY_EN:
- Defined: on the first timeout of a request, do not pulse o_timeout. Return to DLE0 and resend the identical frame, then wait again with a fresh counter. o_timeout pulses only after the second timeout. o_done on either attempt ends the request normally. o_busy stays high throughout.
- Undefined: a single attempt; the first timeout pulses o_timeout.

Test Plan:
1. Reset, then req0 id=8'h8E, has_param=1, param=8'hA5, rsp_id=8'h8F, i_tx_ready=1 -> o_ack[0] next cycle. Tx sequence 10 8E A5 10 03, one byte per cycle. i_rsp_dv id 8F 50 cycles later -> o_done[0] pulse, o_busy low after.
2. req1 id=8'h10, no param, i_tx_ready toggling 1/0 -> sequence 10 10 10 10 03, each byte held stable while ready=0.
3. req0 and req1 both held continuously -> acks alternate 0,1,0,1; first grant is req0.
4. TIMEOUT_CYC=100 (override); send, then only i_rsp_id=8'h41 pulses -> o_timeout pulses exactly 100 cycles after ETX acceptance, no o_done. With THUNDER_SCHED_RETRY_EN: frame resent, timeout after the second 100-cycle window.
5. Matching i_rsp_dv in the exact expiry cycle -> o_done only.
6. i_rst asserted mid-frame after the ID byte -> o_tx_dv 0 in the first reset cycle, no done/timeout. After release, req0 is granted first.

Source files
------------

// File: rtl/thunder_cmd_sched_if.sv
// Request, response and UART-transmit bundle between the command scheduler
// and its requesters, the TSIP packet receiver and the transmit UART.
interface thunder_cmd_sched_if;
    logic [1:0]  i_req;
    logic [15:0] i_req_id;
    logic [15:0] i_req_param;
    logic [1:0]  i_req_has_param;
    logic [15:0] i_req_rsp_id;
    logic [1:0]  o_ack;
    logic [1:0]  o_done;
    logic [1:0]  o_timeout;
    logic        o_busy;
    logic [7:0]  o_tx_byte;
    logic        o_tx_dv;
    logic        i_tx_ready;
    logic        i_rsp_dv;
    logic [7:0]  i_rsp_id;

    modport slave (
        input  i_req, i_req_id, i_req_param, i_req_has_param, i_req_rsp_id,
        input  i_tx_ready, i_rsp_dv, i_rsp_id,
        output o_ack, o_done, o_timeout, o_busy, o_tx_byte, o_tx_dv
    );

    modport master (
        output i_req, i_req_id, i_req_param, i_req_has_param, i_req_rsp_id,
        output i_tx_ready, i_rsp_dv, i_rsp_id,
        input  o_ack, o_done, o_timeout, o_busy, o_tx_byte, o_tx_dv
    );
endinterface

// File: rtl/thunder_cmd_sched.sv
// Two-requester TSIP command scheduler: round-robin grant, DLE-stuffed framing,
// response wait with timeout. Define THUNDER_SCHED_RETRY_EN to resend once on timeout.
module thunder_cmd_sched #(
    parameter int unsigned TIMEOUT_CYC = 10000000,
    parameter logic [7:0]  DLE         = 8'h10,
    parameter logic [7:0]  ETX         = 8'h03
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    thunder_cmd_sched_if.slave   s_if
);

    localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DLE0,
        ST_ID,
        ST_ID_ESC,
        ST_PARAM,
        ST_PARAM_ESC,
        ST_DLE1,
        ST_ETX,
        ST_WAIT_RSP,
        ST_FIN
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_gnt;
    logic        r_retry;
    logic [7:0]  r_id;
    logic [7:0]  r_param;
    logic        r_has_param;
    logic [7:0]  r_rsp_id;
    logic [23:0] r_cnt;
    logic [1:0]  r_ack;
    logic [1:0]  r_done;
    logic [1:0]  r_timeout;
    logic        r_busy;
    logic [7:0]  r_tx_byte;
    logic        r_tx_dv;

    logic [7:0]  w_req_id        [2];
    logic [7:0]  w_req_param     [2];
    logic [7:0]  w_req_rsp_id    [2];
    logic        w_req_has_param [2];
    logic        w_grant;
    logic        w_rsp_match;
    state_t      w_adv_state;
    logic [7:0]  w_adv_byte;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign w_req_id[gi]        = s_if.i_req_id[8*gi +: 8];
        assign w_req_param[gi]     = s_if.i_req_param[8*gi +: 8];
        assign w_req_rsp_id[gi]    = s_if.i_req_rsp_id[8*gi +: 8];
        assign w_req_has_param[gi] = s_if.i_req_has_param[gi];
    end

    // With both requesting, the one after the last served wins; otherwise the lone one.
    assign w_grant     = (s_if.i_req == 2'b11) ? ~r_last : s_if.i_req[1];
    assign w_rsp_match = s_if.i_rsp_dv && (s_if.i_rsp_id == r_rsp_id);

    // Successor state and its byte once the current frame byte is accepted.
    always_comb begin
        w_adv_state = ST_IDLE;
        w_adv_byte  = DLE;
        case (r_state)
            ST_DLE0: begin
                w_adv_state = ST_ID;
                w_adv_byte  = r_id;
            end
            ST_ID: begin
                if (r_id == DLE) begin
                    w_adv_state = ST_ID_ESC;
                    w_adv_byte  = DLE;
                end else if (r_has_param) begin
                    w_adv_state = ST_PARAM;
                    w_adv_byte  = r_param;
                end else begin
                    w_adv_state = ST_DLE1;
                    w_adv_byte  = DLE;
                end
            end
            ST_ID_ESC: begin
                if (r_has_param) begin
                    w_adv_state = ST_PARAM;
                    w_adv_byte  = r_param;
                end else begin
                    w_adv_state = ST_DLE1;
                    w_adv_byte  = DLE;
                end
            end
            ST_PARAM: begin
                w_adv_state = (r_param == DLE) ? ST_PARAM_ESC : ST_DLE1;
                w_adv_byte  = DLE;
            end
            ST_PARAM_ESC: begin
                w_adv_state = ST_DLE1;
                w_adv_byte  = DLE;
            end
            ST_DLE1: begin
                w_adv_state = ST_ETX;
                w_adv_byte  = ETX;
            end
            ST_ETX: begin
                w_adv_state = ST_WAIT_RSP;
                w_adv_byte  = DLE;
            end
            default: begin
                w_adv_state = ST_IDLE;
                w_adv_byte  = DLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_retry     <= 1'b0;
            r_id        <= '0;
            r_param     <= '0;
            r_has_param <= 1'b0;
            r_rsp_id    <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_done      <= '0;
            r_timeout   <= '0;
            r_busy      <= 1'b0;
            r_tx_byte   <= '0;
            r_tx_dv     <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_done    <= '0;
            r_timeout <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|s_if.i_req) begin
                        r_ack[w_grant] <= 1'b1;
                        r_gnt          <= w_grant;
                        r_last         <= w_grant;
                        r_id           <= w_req_id[w_grant];
                        r_param        <= w_req_param[w_grant];
                        r_has_param    <= w_req_has_param[w_grant];
                        r_rsp_id       <= w_req_rsp_id[w_grant];
                        r_retry        <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= ST_DLE0;
                    end
                end
                // The ack cycle (and a resend entry) arrives with tx_dv low; load the first DLE.
                ST_DLE0: begin
                    if (!r_tx_dv) begin
                        r_tx_dv   <= 1'b1;
                        r_tx_byte <= DLE;
                    end else if (s_if.i_tx_ready) begin
                        r_state   <= w_adv_state;
                        r_tx_byte <= w_adv_byte;
                    end
                end
                ST_ID, ST_ID_ESC, ST_PARAM, ST_PARAM_ESC, ST_DLE1: begin
                    if (s_if.i_tx_ready) begin
                        r_state   <= w_adv_state;
                        r_tx_byte <= w_adv_byte;
                    end
                end
                ST_ETX: begin
                    if (s_if.i_tx_ready) begin
                        r_state <= ST_WAIT_RSP;
                        r_tx_dv <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (w_rsp_match) begin
                        r_state       <= ST_FIN;
                        r_done[r_gnt] <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
`ifdef THUNDER_SCHED_RETRY_EN
                        if (!r_retry) begin
                            r_retry <= 1'b1;
                            r_state <= ST_DLE0;
                        end else begin
                            r_state          <= ST_FIN;
                            r_timeout[r_gnt] <= 1'b1;
                        end
`else
                        r_state          <= ST_FIN;
                        r_timeout[r_gnt] <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx_dv <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.o_ack     = r_ack;
    assign s_if.o_done    = r_done;
    assign s_if.o_timeout = r_timeout;
    assign s_if.o_busy    = r_busy;
    assign s_if.o_tx_byte = r_tx_byte;
    assign s_if.o_tx_dv   = r_tx_dv;

endmodule

// File: tb/tb_thunder_cmd_sched.sv
// Directed bench for thunder_cmd_sched with a 100-cycle timeout; follows
// THUNDER_SCHED_RETRY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_thunder_cmd_sched;

    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thunder_cmd_sched_if sif ();

    thunder_cmd_sched #(.TIMEOUT_CYC(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_if  (sif)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [7:0] tx_q [$];
    int         ack_q [$];
    int         first_cyc = 0;
    int         etx_cyc   = 0;
    int         etx_cnt   = 0;
    int         done_cnt  = 0;
    int         to_cnt    = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    always @(posedge clk) cyc++;

    // Monitor samples at negedge: exactly the values the next posedge will act on.
    always @(negedge clk) begin
        if (prev_hold && !rst) begin
            check_val("tx_hold_dv", 32'(sif.o_tx_dv), 32'd1);
            check_val("tx_hold_byte", 32'(sif.o_tx_byte), 32'(prev_byte));
        end
        prev_hold = sif.o_tx_dv && !sif.i_tx_ready && !rst;
        prev_byte = sif.o_tx_byte;
        if (sif.o_tx_dv && sif.i_tx_ready) begin
            if (tx_q.size() == 0) first_cyc = cyc;
            tx_q.push_back(sif.o_tx_byte);
            if (sif.o_tx_byte == 8'h03) begin
                etx_cyc = cyc;
                etx_cnt++;
            end
        end
        if (sif.o_ack != 2'b00) ack_q.push_back(int'(sif.o_ack));
        if (sif.o_done != 2'b00) done_cnt++;
        if (sif.o_timeout != 2'b00) to_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int g, input logic [7:0] id, input logic [7:0] param,
                         input logic has, input logic [7:0] rsp);
        int c0;
        int waited;
        sif.i_req_id[8*g +: 8]    = id;
        sif.i_req_param[8*g +: 8] = param;
        sif.i_req_has_param[g]    = has;
        sif.i_req_rsp_id[8*g +: 8] = rsp;
        sif.i_req[g] = 1'b1;
        c0 = cyc;
        waited = 0;
        step();
        while (sif.o_ack == 2'b00 && waited < 20) begin
            step();
            waited++;
        end
        check_val("ack_onehot", 32'(sif.o_ack), 32'(1 << g));
        check_val("ack_latency", 32'(cyc - c0), 32'd1);
        check_val("ack_busy", 32'(sif.o_busy), 32'd1);
        check_val("ack_tx_dv_low", 32'(sif.o_tx_dv), 32'd0);
        sif.i_req[g] = 1'b0;
        step();
        check_val("tx_dv_rise", 32'(sif.o_tx_dv), 32'd1);
        check_val("tx_first_dle", 32'(sif.o_tx_byte), 32'h10);
    endtask

    task automatic wait_frame(input int n, input int bound);
        int waited = 0;
        while (tx_q.size() < n && waited < bound) begin
            step();
            waited++;
        end
    endtask

    task automatic check_frame(input string tag, input int n, input logic [63:0] exp);
        check_val({tag, "_len"}, 32'(tx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] got;
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check_val($sformatf("%s_b%0d", tag, i), 32'(got), 32'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    task automatic pulse_rsp(input logic [7:0] id);
        sif.i_rsp_dv = 1'b1;
        sif.i_rsp_id = id;
        step();
        sif.i_rsp_dv = 1'b0;
        sif.i_rsp_id = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int t0;
        int k;
        int waited;

        sif.i_req           = 2'b00;
        sif.i_req_id        = 16'h0000;
        sif.i_req_param     = 16'h0000;
        sif.i_req_has_param = 2'b00;
        sif.i_req_rsp_id    = 16'h0000;
        sif.i_tx_ready      = 1'b1;
        sif.i_rsp_dv        = 1'b0;
        sif.i_rsp_id        = 8'h00;

        // Reset state
        step(3);
        check_val("rst_ack", 32'(sif.o_ack), 32'd0);
        check_val("rst_done", 32'(sif.o_done), 32'd0);
        check_val("rst_timeout", 32'(sif.o_timeout), 32'd0);
        check_val("rst_busy", 32'(sif.o_busy), 32'd0);
        check_val("rst_tx_dv", 32'(sif.o_tx_dv), 32'd0);
        rst = 1'b0;
        step(2);

        // 1: req0 with parameter, response 50 cycles after ETX
        $display("T1 req0 id=8E param=A5 rsp=8F");
        tx_q.delete();
        issue(0, 8'h8E, 8'hA5, 1'b1, 8'h8F);
        wait_frame(5, 20);
        check_frame("t1_frame", 5, 64'h10_8E_A5_10_03);
        check_val("t1_byte_per_cycle", 32'(etx_cyc - first_cyc), 32'd4);
        step(49);
        check_val("t1_busy_wait", 32'(sif.o_busy), 32'd1);
        pulse_rsp(8'h8F);
        check_val("t1_done", 32'(sif.o_done), 32'h1);
        check_val("t1_no_timeout", 32'(sif.o_timeout), 32'd0);
        check_val("t1_busy_fin", 32'(sif.o_busy), 32'd1);
        step();
        check_val("t1_done_pulse", 32'(sif.o_done), 32'd0);
        check_val("t1_busy_low", 32'(sif.o_busy), 32'd0);

        // 2: req1 id=DLE, no param, ready toggling, matching rsp during send ignored
        $display("T2 req1 id=10 no param, ready toggling");
        tx_q.delete();
        d0 = done_cnt;
        issue(1, 8'h10, 8'h00, 1'b0, 8'h90);
        for (int i = 0; i < 40 && tx_q.size() < 5; i++) begin
            sif.i_tx_ready = (i % 2) == 1;
            sif.i_rsp_dv   = (i == 2);
            sif.i_rsp_id   = (i == 2) ? 8'h90 : 8'h00;
            step();
        end
        sif.i_tx_ready = 1'b1;
        sif.i_rsp_dv   = 1'b0;
        check_frame("t2_frame", 5, 64'h10_10_10_10_03);
        check_val("t2_rsp_in_send_ignored", 32'(done_cnt - d0), 32'd0);
        check_val("t2_busy_wait", 32'(sif.o_busy), 32'd1);
        step(5);
        pulse_rsp(8'h90);
        check_val("t2_done", 32'(sif.o_done), 32'h2);
        step();

        // 3: both held, grants alternate starting with req0
        $display("T3 both requesters held");
        ack_q.delete();
        t0 = to_cnt;
        sif.i_req_id        = 16'h2221;
        sif.i_req_param     = 16'h0000;
        sif.i_req_has_param = 2'b00;
        sif.i_req_rsp_id    = 16'h3231;
        sif.i_req           = 2'b11;
        waited = 0;
        while (ack_q.size() < 4 && waited < 4000) begin
            step();
            waited++;
        end
        sif.i_req = 2'b00;
        waited = 0;
        while (sif.o_busy && waited < 1000) begin
            step();
            waited++;
        end
        check_val("t3_ack_count", 32'(ack_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            int got;
            got = (i < ack_q.size()) ? ack_q[i] : -1;
            check_val($sformatf("t3_ack%0d", i), 32'(got), ((i % 2) == 0) ? 32'd1 : 32'd2);
        end
        check_val("t3_timeouts", 32'(to_cnt - t0), 32'd4);
        step();

        // 4: only non-matching responses -> timeout TO edges after the ETX-accepting edge
        $display("T4 timeout with non-matching responses");
        tx_q.delete();
        d0 = done_cnt;
        t0 = to_cnt;
        issue(0, 8'h40, 8'h00, 1'b0, 8'h42);
        wait_frame(4, 20);
        step(10);
        pulse_rsp(8'h41);
        step(20);
        pulse_rsp(8'h41);
        step(30);
        pulse_rsp(8'h41);
        waited = 0;
        while (sif.o_timeout == 2'b00 && waited < 400) begin
            step();
            waited++;
        end
`ifdef THUNDER_SCHED_RETRY_EN
        check_frame("t4_frames", 8, 64'h10_40_10_03_10_40_10_03);
`else
        check_frame("t4_frame", 4, 64'h10_40_10_03);
`endif
        check_val("t4_timeout_cycle", 32'(cyc - etx_cyc), 32'(TO + 1));
        check_val("t4_timeout", 32'(sif.o_timeout), 32'h1);
        check_val("t4_no_done", 32'(sif.o_done), 32'd0);
        step();
        check_val("t4_busy_low", 32'(sif.o_busy), 32'd0);
        check_val("t4_done_count", 32'(done_cnt - d0), 32'd0);
        check_val("t4_timeout_count", 32'(to_cnt - t0), 32'd1);

        // 5: matching response in the exact expiry cycle -> done only
        $display("T5 match in expiry cycle");
        tx_q.delete();
        t0 = to_cnt;
        issue(0, 8'h40, 8'h00, 1'b0, 8'h42);
        wait_frame(4, 20);
        k = etx_cyc;
        while (cyc < k + TO) step();
        sif.i_rsp_dv = 1'b1;
        sif.i_rsp_id = 8'h42;
        step();
        sif.i_rsp_dv = 1'b0;
        check_val("t5_done", 32'(sif.o_done), 32'h1);
        check_val("t5_no_timeout", 32'(sif.o_timeout), 32'd0);
        step();
        check_val("t5_busy_low", 32'(sif.o_busy), 32'd0);
        check_val("t5_timeout_count", 32'(to_cnt - t0), 32'd0);

        // 6: reset after ID byte, then req0 wins over req1 again
        $display("T6 reset mid-frame");
        tx_q.delete();
        d0 = done_cnt;
        t0 = to_cnt;
        issue(0, 8'h55, 8'h66, 1'b1, 8'h77);
        wait_frame(2, 20);
        rst = 1'b1;
        step();
        check_val("t6_rst_tx_dv", 32'(sif.o_tx_dv), 32'd0);
        check_val("t6_rst_busy", 32'(sif.o_busy), 32'd0);
        step(2);
        rst = 1'b0;
        step();
        check_val("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("t6_no_timeout", 32'(to_cnt - t0), 32'd0);
        tx_q.delete();
        sif.i_req_id        = 16'h6261;
        sif.i_req_has_param = 2'b00;
        sif.i_req_rsp_id    = 16'h7271;
        sif.i_req           = 2'b11;
        step();
        check_val("t6_first_grant", 32'(sif.o_ack), 32'h1);
        sif.i_req = 2'b00;
        wait_frame(4, 20);
        check_frame("t6_frame", 4, 64'h10_61_10_03);
        step(3);
        pulse_rsp(8'h71);
        check_val("t6_done", 32'(sif.o_done), 32'h1);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
